// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, datapath
// select codes, opcode/func constants and the instruction-class record.
package mc_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MDWAIT = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;

  localparam logic [1:0] DM_WORD = 2'd0;
  localparam logic [1:0] DM_HALF = 2'd1;
  localparam logic [1:0] DM_BYTE = 2'd2;

  localparam logic EXT_ZERO   = 1'b0;
  localparam logic EXT_SIGNED = 1'b1;

  localparam logic [1:0] M1_RT  = 2'd0;
  localparam logic [1:0] M1_RD  = 2'd1;
  localparam logic [1:0] M1_R31 = 2'd2;

  localparam logic [2:0] M2_ALU = 3'd0;
  localparam logic [2:0] M2_DM  = 3'd1;
  localparam logic [2:0] M2_NPC = 3'd2;
  localparam logic [2:0] M2_LUI = 3'd3;
  localparam logic [2:0] M2_HI  = 3'd4;
  localparam logic [2:0] M2_LO  = 3'd5;

  localparam logic [1:0] M3_RT  = 2'd0;
  localparam logic [1:0] M3_EXT = 2'd1;

  localparam logic M4_RS    = 1'b0;
  localparam logic M4_SHAMT = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef struct packed {
    logic addu, subu, or_r, slt, sltu, sll, jr;
    logic mfhi, mflo, md;
    logic ori, lui;
    logic lw, lh, lhu, lb, lbu;
    logic sw, sh, sb;
    logic beq, j, jal;
    logic unknown;
  } dec_t;

  function automatic logic is_load(input dec_t d);
    return d.lw | d.lh | d.lhu | d.lb | d.lbu;
  endfunction

  function automatic logic is_store(input dec_t d);
    return d.sw | d.sh | d.sb;
  endfunction

  function automatic logic [3:0] alu_sel(input dec_t d);
    if (d.subu | d.beq)     return ALU_SUB;
    else if (d.or_r | d.ori) return ALU_OR;
    else if (d.slt)          return ALU_SLT;
    else if (d.sltu)         return ALU_SLTU;
    else if (d.sll)          return ALU_SLL;
    else                     return ALU_ADD;
  endfunction

  function automatic logic [1:0] dm_sel(input dec_t d);
    if (d.lh | d.lhu | d.sh)      return DM_HALF;
    else if (d.lb | d.lbu | d.sb) return DM_BYTE;
    else                          return DM_WORD;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction-class decoder (op/func -> one-hot record).
// Mul/div encodings are recognised only when MC_CTRL_MULDIV_EN is defined.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    // NOTE: defaulting the whole record first keeps every branch latch-free.
    dec = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADDU: dec.addu = 1'b1;
          F_SUBU: dec.subu = 1'b1;
          F_OR:   dec.or_r = 1'b1;
          F_SLT:  dec.slt  = 1'b1;
          F_SLTU: dec.sltu = 1'b1;
          F_SLL:  dec.sll  = 1'b1;
          F_JR:   dec.jr   = 1'b1;
`ifdef MC_CTRL_MULDIV_EN
          F_MULT, F_MULTU, F_DIV, F_DIVU: dec.md = 1'b1;
          F_MFHI: dec.mfhi = 1'b1;
          F_MFLO: dec.mflo = 1'b1;
`endif
          default: dec.unknown = 1'b1;
        endcase
      end
      OP_ORI:  dec.ori = 1'b1;
      OP_LUI:  dec.lui = 1'b1;
      OP_LW:   dec.lw  = 1'b1;
      OP_LH:   dec.lh  = 1'b1;
      OP_LHU:  dec.lhu = 1'b1;
      OP_LB:   dec.lb  = 1'b1;
      OP_LBU:  dec.lbu = 1'b1;
      OP_SW:   dec.sw  = 1'b1;
      OP_SH:   dec.sh  = 1'b1;
      OP_SB:   dec.sb  = 1'b1;
      OP_BEQ:  dec.beq = 1'b1;
      OP_J:    dec.j   = 1'b1;
      OP_JAL:  dec.jal = 1'b1;
      default: dec.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// handshake with timeout, retired-instruction counter. Option: MC_CTRL_MULDIV_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             md_busy,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             dm_wr,
  output logic             mem_req,
  output logic [2:0]       npc_op,
  output logic [3:0]       alu_op,
  output logic             ext_op,
  output logic [1:0]       dm_op,
  output logic             if_signed,
  output logic [1:0]       m1_sel,
  output logic [2:0]       m2_sel,
  output logic [1:0]       m3_sel,
  output logic             m4_sel,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             illegal,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

  dec_t            d;
  logic [2:0]      state_nx;
  logic [WC_W-1:0] wait_cnt;
  logic            retire, md_busy_eff, mf_wait;
  logic            ir_we_r, rf_we_r, dm_wr_r, mem_req_r, md_start_r, illegal_r;
  logic [1:0]      md_op_r;

  mc_decode u_decode (.op(op), .func(func), .dec(d));

`ifdef MC_CTRL_MULDIV_EN
  assign md_busy_eff = md_busy;
  assign md_start    = md_start_r & ~reset;
  assign md_op       = md_op_r;
`else
  logic unused_md;
  assign unused_md   = ^{md_busy, md_start_r, md_op_r};
  assign md_busy_eff = 1'b0;
  assign md_start    = 1'b0;
  assign md_op       = 2'd0;
`endif

  assign mf_wait = (d.mfhi | d.mflo) & md_busy_eff;

  always_comb begin
    state_nx   = state;
    retire     = 1'b0;
    ir_we_r    = 1'b0;
    rf_we_r    = 1'b0;
    dm_wr_r    = 1'b0;
    mem_req_r  = 1'b0;
    md_start_r = 1'b0;
    md_op_r    = 2'd0;
    illegal_r  = 1'b0;
    npc_op     = NPC_PC4;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;
    dm_op      = DM_WORD;
    if_signed  = 1'b0;
    m1_sel     = M1_RT;
    m2_sel     = M2_ALU;
    m3_sel     = M3_RT;
    m4_sel     = M4_RS;
    case (state)
      S_FETCH: begin
        ir_we_r  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (d.j | d.jr | d.jal) begin
          retire = 1'b1;
          npc_op = d.jr ? NPC_JR : NPC_J;
          if (d.jal) begin
            rf_we_r = 1'b1;
            m1_sel  = M1_R31;
            m2_sel  = M2_NPC;
          end
        end else if (d.unknown) begin
          retire    = 1'b1;
          illegal_r = 1'b1;
        end else if (mf_wait) begin
          state_nx = S_MDWAIT;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = alu_sel(d);
        if (is_load(d) | is_store(d)) begin
          m3_sel   = M3_EXT;
          ext_op   = EXT_SIGNED;
          state_nx = S_MEM;
        end else if (d.beq) begin
          retire = 1'b1;
          npc_op = zero ? NPC_BEQ : NPC_PC4;
        end else if (d.md) begin
          md_start_r = 1'b1;
          md_op_r    = func[1:0];
          state_nx   = S_MDWAIT;
        end else begin
          if (d.ori) m3_sel = M3_EXT;
          if (d.sll) m4_sel = M4_SHAMT;
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        mem_req_r = 1'b1;
        dm_wr_r   = is_store(d);
        dm_op     = dm_sel(d);
        if_signed = d.lb | d.lh;
        // A ready on the last allowed cycle still completes the access.
        if (mem_ready) begin
          if (is_store(d)) retire = 1'b1;
          else             state_nx = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_ERR;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        rf_we_r = 1'b1;
        m1_sel  = (d.ori | d.lui | is_load(d)) ? M1_RT : M1_RD;
        if (is_load(d)) begin
          m2_sel    = M2_DM;
          dm_op     = dm_sel(d);
          if_signed = d.lb | d.lh;
        end else if (d.lui)  m2_sel = M2_LUI;
        else if (d.mfhi)     m2_sel = M2_HI;
        else if (d.mflo)     m2_sel = M2_LO;
      end
      S_MDWAIT: begin
        if (!md_busy_eff) begin
          if (d.md) retire = 1'b1;
          else      state_nx = S_EXEC;
        end
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_FETCH;
    endcase
    if (retire) state_nx = S_FETCH;
  end

  assign ir_we   = ir_we_r   & ~reset;
  assign pc_we   = retire    & ~reset;
  assign rf_we   = rf_we_r   & ~reset;
  assign dm_wr   = dm_wr_r   & ~reset;
  assign mem_req = mem_req_r & ~reset;
  assign illegal = illegal_r & ~reset;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      err      <= 1'b0;
      instret  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == S_MEM) ? wait_cnt + 1'b1 : '0;
      if (state_nx == S_ERR) err <= 1'b1;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a scoreboard queue holds the expected
// retirement of each instruction and is checked when the DUT retires it.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0, md_busy = 1'b0;
  logic       ir_we, pc_we, rf_we, dm_wr, mem_req, ext_op, if_signed, m4_sel;
  logic       md_start, illegal, err;
  logic [2:0] npc_op, m2_sel, state;
  logic [3:0] alu_op, instret;
  logic [1:0] dm_op, m1_sel, m3_sel, md_op;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(4), .WAIT_MAX(16)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .md_busy(md_busy),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .dm_wr(dm_wr), .mem_req(mem_req),
    .npc_op(npc_op), .alu_op(alu_op), .ext_op(ext_op), .dm_op(dm_op),
    .if_signed(if_signed), .m1_sel(m1_sel), .m2_sel(m2_sel), .m3_sel(m3_sel),
    .m4_sel(m4_sel), .md_start(md_start), .md_op(md_op), .illegal(illegal),
    .err(err), .instret(instret), .state(state)
  );

  typedef struct {
    string tag;
    int    cycles;
    int    npc;
    int    illegal;
    int    instret;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_instret;
  int passed = 0, total = 0, failed = 0;

  int obs_cycles, obs_npc, obs_illegal, obs_pcwe, obs_pc_state;
  int obs_rf, obs_rf_state, obs_m1, obs_m2, obs_req, obs_wr, obs_dm, obs_sgn;
  int obs_alu, obs_m3, obs_m4, obs_ext, obs_mds, obs_mdop;
  logic [31:0] obs_sig;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    mem_ready = 1'b0;
    md_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(state), 0);
    check({tag, ".err"}, 32'(err), 0);
    check({tag, ".instret"}, 32'(instret), 0);
    check({tag, ".ir_we_in_reset"}, 32'(ir_we), 0);
    reset = 1'b0;
    #1;
    check({tag, ".ir_we_after"}, 32'(ir_we), 1);
    m_instret = 4'd0;
  endtask

  task automatic expect_retire(input string tag, input int cycles, input int npc, input int ill);
    exp_t e;
    m_instret = m_instret + 4'd1;
    e.tag = tag; e.cycles = cycles; e.npc = npc; e.illegal = ill; e.instret = int'(m_instret);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".cycles"}, obs_cycles, e.cycles);
    check({e.tag, ".npc_op"}, obs_npc, e.npc);
    check({e.tag, ".illegal"}, obs_illegal, e.illegal);
    check({e.tag, ".pc_we_count"}, obs_pcwe, 1);
    check({e.tag, ".instret"}, 32'(instret), e.instret);
  endtask

  // Runs one instruction from FETCH; memory and mul/div unit react to the DUT's requests.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int mem_delay, input int busy_cycles, input int limit);
    int   busy_left;
    logic retired;
    busy_left = 0; retired = 1'b0;
    obs_cycles = 0; obs_npc = 0; obs_illegal = 0; obs_pcwe = 0; obs_pc_state = 0;
    obs_rf = 0; obs_rf_state = 0; obs_m1 = 0; obs_m2 = 0; obs_req = 0; obs_wr = 0;
    obs_dm = 0; obs_sgn = 0; obs_alu = 0; obs_m3 = 0; obs_m4 = 0; obs_ext = 0;
    obs_mds = 0; obs_mdop = 0; obs_sig = '0;
    op = o; func = f; zero = z;
    for (int c = 0; c < limit && !retired; c++) begin
      mem_ready = mem_req && (mem_delay >= 0) && (obs_req == mem_delay);
      md_busy = (busy_left > 0);
      @(negedge clk);
      obs_sig = (obs_sig << 3) | 32'(state);
      if (state == 3'd2) begin
        obs_alu = int'(alu_op); obs_m3 = int'(m3_sel); obs_m4 = int'(m4_sel); obs_ext = int'(ext_op);
      end
      if (mem_req) begin
        if (obs_req == 0) begin obs_dm = int'(dm_op); obs_sgn = int'(if_signed); end
        obs_req++;
      end
      if (dm_wr) obs_wr++;
      if (rf_we) begin
        obs_rf++; obs_rf_state = int'(state); obs_m1 = int'(m1_sel); obs_m2 = int'(m2_sel);
      end
      if (illegal) obs_illegal++;
      if (md_busy) busy_left--;
      if (md_start) begin obs_mds++; obs_mdop = int'(md_op); busy_left = busy_cycles; end
      if (pc_we) begin
        obs_pcwe++; obs_npc = int'(npc_op); obs_pc_state = int'(state);
        obs_cycles = c + 1; retired = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    md_busy = 1'b0;
  endtask

  initial begin
    m_instret = 4'd0;
    apply_reset("reset0");

    expect_retire("addu", 4, 0, 0);
    run_instr(6'h00, 6'h21, 1'b0, 0, 0, 20);
    pop_check();
    check("addu.states", obs_sig, 32'o0124);
    check("addu.rf_we_count", obs_rf, 1);
    check("addu.rf_we_state", obs_rf_state, 4);
    check("addu.m1_sel", obs_m1, 1);

    expect_retire("beq_taken", 3, 1, 0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 20);
    pop_check();
    check("beq_taken.alu_op", obs_alu, 1);
    expect_retire("beq_not", 3, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 20);
    pop_check();

    expect_retire("ori", 4, 0, 0);
    run_instr(6'h0D, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("ori.alu_op", obs_alu, 2);
    check("ori.m3_sel", obs_m3, 1);
    check("ori.ext_op", obs_ext, 0);
    check("ori.m1_sel", obs_m1, 0);
    check("ori.m2_sel", obs_m2, 0);

    expect_retire("lui", 4, 0, 0);
    run_instr(6'h0F, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("lui.m2_sel", obs_m2, 3);

    expect_retire("sll", 4, 0, 0);
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("sll.alu_op", obs_alu, 4);
    check("sll.m4_sel", obs_m4, 1);
    check("sll.m1_sel", obs_m1, 1);

    expect_retire("lw", 8, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 3, 0, 30);
    pop_check();
    check("lw.states", obs_sig, 32'o01233334);
    check("lw.mem_req_cycles", obs_req, 4);
    check("lw.dm_op", obs_dm, 0);
    check("lw.m2_sel", obs_m2, 1);
    check("lw.ext_op", obs_ext, 1);

    expect_retire("lb", 5, 0, 0);
    run_instr(6'h20, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("lb.dm_op", obs_dm, 2);
    check("lb.if_signed", obs_sgn, 1);
    check("lb.m1_sel", obs_m1, 0);

    expect_retire("sw", 4, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("sw.dm_wr_cycles", obs_wr, 1);
    check("sw.retire_state", obs_pc_state, 3);
    check("sw.rf_we_count", obs_rf, 0);

    expect_retire("sw_boundary", 19, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 15, 0, 40);
    pop_check();
    check("sw_boundary.err", 32'(err), 0);

    // Reset landing in WB must suppress the pending retire.
    op = 6'h00; func = 6'h21;
    repeat (3) begin @(posedge clk); #1; end
    check("midreset.state", 32'(state), 4);
    reset = 1'b1;
    #1;
    check("midreset.pc_we", 32'(pc_we), 0);
    check("midreset.rf_we", 32'(rf_we), 0);
    apply_reset("reset1");

    run_instr(6'h2B, 6'h00, 1'b0, -1, 0, 25);
    check("sw_timeout.pc_we_count", obs_pcwe, 0);
    check("sw_timeout.mem_req_cycles", obs_req, 16);
    check("sw_timeout.err", 32'(err), 1);
    check("sw_timeout.state", 32'(state), 6);
    check("sw_timeout.ir_we", 32'(ir_we), 0);
    apply_reset("reset2");

    expect_retire("jal", 2, 2, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, 20);
    pop_check();
    check("jal.m1_sel", obs_m1, 2);
    check("jal.m2_sel", obs_m2, 2);
    check("jal.rf_we_state", obs_rf_state, 1);

    expect_retire("illegal_op", 2, 0, 1);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 20);
    pop_check();

    for (int i = 0; i < 14; i++) begin
      expect_retire("j_wrap", 2, 2, 0);
      run_instr(6'h02, 6'h00, 1'b0, 0, 0, 20);
      pop_check();
    end
    check("wrap.instret", 32'(instret), 0);

`ifdef MC_CTRL_MULDIV_EN
    expect_retire("mult", 9, 0, 0);
    run_instr(6'h00, 6'h18, 1'b0, 0, 5, 30);
    pop_check();
    check("mult.md_start_count", obs_mds, 1);
    check("mult.md_op", obs_mdop, 0);
    check("mult.retire_state", obs_pc_state, 5);
`else
    expect_retire("mult_disabled", 2, 0, 1);
    run_instr(6'h00, 6'h18, 1'b0, 0, 5, 20);
    pop_check();
    check("mult_disabled.md_start_count", obs_mds, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the multi-cycle MIPS datapath. Decodes `op`/`func` from the instruction register and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives every datapath enable and mux select, handshakes with data memory (`mem_req`/`mem_ready`) under a bounded timeout, and counts retired instructions. It replaces the single-cycle combinational decoder and keeps the same instruction set and select encodings.

## Interface
- `CNT_W`, 32: width of retired-instruction counter `instret`.
- `WAIT_MAX`, 16: maximum cycles spent in MEM waiting for `mem_ready` before error.

- `clk`  in  1  clock; single clock domain, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  IR[31:26]; stable from DECODE to end of instruction.
- `func`  in  6  IR[5:0].
- `zero`  in  1  ALU equality flag, valid in EXEC.
- `mem_ready`  in  1  data memory completion strobe.
- `md_busy`  in  1  mul/div unit busy (MULDIV_EN only).
- `ir_we`, `pc_we`, `rf_we`, `dm_wr`, `mem_req`  out  1  enables.
- `npc_op`  out  3;  `alu_op`  out  4;  `ext_op`  out  1;  `dm_op`  out  2;  `if_signed`  out  1.
- `m1_sel`  out  2 (RF write addr);  `m2_sel`  out  3 (RF write data);  `m3_sel`  out  2 (ALU B);  `m4_sel`  out  1 (shift amount).
- `md_start`  out  1;  `md_op`  out  2 (MULDIV_EN only).
- `illegal`  out  1  one-cycle pulse when an unknown instruction is retired.
- `err`  out  1  sticky memory-timeout flag.
- `instret`  out  CNT_W  retired-instruction count.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, ERR=6.
- FETCH: `ir_we`=1 -> DECODE.
- DECODE: j/jr/jal retire here. jal also asserts `rf_we` with `m1_sel`=R31 and `m2_sel`=NPC. Unknown op/func retires as a nop with `illegal`=1. Everything else -> EXEC.
- EXEC: ALU selects are driven.
  - R-type, ori, lui -> WB.
  - Loads and stores -> MEM.
  - beq retires with `npc_op`=BEQ if `zero`, else PC4.
- MEM: `mem_req`=1, plus `dm_wr` for stores. `dm_op` and `if_signed` are held.
  - On `mem_ready`: stores retire; loads -> WB.
  - On the WAIT_MAX-th cycle without `mem_ready`: -> ERR.
- WB: `rf_we`=1 -> retire.
- Retire means: `pc_we`=1 (exactly once per instruction), `instret`+1 (wraps modulo 2^CNT_W), next state FETCH.
- ERR: all enables 0, `err`=1. Left only by reset.
- Selects follow the established mapping: Rd for R-type, Rt for ori/lui/loads. EXT for ori/loads/stores. ext_op ZERO for ori, SIGNED for memory ops. ALU ADD for memory ops, SUB for beq, SHAMT for sll. `if_signed` set for lb/lh.
- Unused selects are 0 in every state.

## Timing
- Cycles per instruction:
  - j/jr/jal: 2.
  - beq: 3.
  - ALU ops and stores with `mem_ready` in the first MEM cycle: 4.
  - Loads: 5 + extra wait cycles.
- Outputs are combinational from registered `state` plus `op`/`func`. `instret`, `err` and `state` are registered.
- While `reset`=1, all enables, `illegal` and `md_start` are forced to 0. Reset takes effect mid-instruction with no partial retire.
- After reset: `state`=FETCH, `err`=0, `instret`=0, so `ir_we`=1 in the first cycle after reset.
- MEM wait counter clears on entry to MEM. `mem_ready` in the same cycle as the timeout boundary wins, and the instruction completes normally.

## Configuration
- `MC_CTRL_MULDIV_EN` defined: mult, multu, div, divu (func 0x18–0x1B) and mfhi/mflo (0x10/0x12) are supported.
  - mult/multu/div/divu: EXEC pulses `md_start` with `md_op`=func[1:0], then MDWAIT until `md_busy`=0, then retire.
  - mfhi/mflo: go DECODE -> MDWAIT while `md_busy`=1, then EXEC -> WB with `m2_sel`=HI(4)/LO(5).
- Not defined: these encodings are illegal (nop plus `illegal` pulse). `md_start` and `md_op` are tied to 0 and `md_busy` is ignored.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings;
  - NPC codes PC4=0, BEQ=1, J=2, JR=3;
  - ALU codes ADD=0, SUB=1, OR=2, SLT=3, SLL=4, SLTU=5;
  - DM codes WORD=0, HALF=1, BYTE=2;
  - EXT codes ZERO=0, SIGNED=1;
  - m1: RT=0, RD=1, R31=2;  m2: ALU=0, DM=1, NPC=2, LUI=3, HI=4, LO=5;  m3: RT=0, EXT=1;  m4: RS=0, SHAMT=1;
  - opcode/func constants.
- One sub-module, `mc_decode`: a purely combinational class decoder (op/func -> instruction one-hots). The FSM, wait counter and `instret` live in the top.

## Test plan
- Reset, then addu (op 0, func 0x21): states 0,1,2,4. `rf_we`=1 only in WB with `m1_sel`=RD. `pc_we` once. `instret`=1.
- beq with `zero`=1 then with `zero`=0: 3 cycles each. Retire with `npc_op`=1 and 0 respectively.
- lw with `mem_ready` held low for 3 cycles: MEM lasts 4 cycles with `mem_req`=1 and `dm_op`=WORD. WB `m2_sel`=DM. Total 8 cycles.
- sw with `mem_ready` never asserted, WAIT_MAX=16: ERR after 16 MEM cycles. `err`=1, no `pc_we`. Reset clears it.
- jal then illegal op 0x3F: jal retires in 2 cycles with `m1_sel`=R31 and `npc_op`=J. Illegal op gives one `illegal` pulse and `instret`+1.
- CNT_W=4, 16 retirements: `instret` wraps to 0. With MC_CTRL_MULDIV_EN, mult with `md_busy` high 5 cycles: one `md_start` pulse, `pc_we` in the cycle after `md_busy` falls.
